// File: rtl/lif_neuron_array_if.sv
// Bus bundle for lif_neuron_array: scan enable, per-neuron currents,
// configuration write port and the registered spike/potential outputs.
interface lif_neuron_array_if #(
    parameter int N_NEURONS = 4,
    parameter int V_WIDTH   = 8,
    parameter int I_WIDTH   = 3
);
    logic                           enable;
    logic [N_NEURONS*I_WIDTH-1:0]   input_current;
    logic                           cfg_we;
    logic [1:0]                     cfg_sel;
    logic [V_WIDTH-1:0]             cfg_data;
    logic [N_NEURONS-1:0]           spike_out;
    logic [V_WIDTH-1:0]             potential_out;
    logic [$clog2(N_NEURONS)-1:0]   potential_idx;
    logic                           step_done;

    modport master (
        output enable, input_current, cfg_we, cfg_sel, cfg_data,
        input  spike_out, potential_out, potential_idx, step_done
    );

    modport slave (
        input  enable, input_current, cfg_we, cfg_sel, cfg_data,
        output spike_out, potential_out, potential_idx, step_done
    );
endinterface

// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons sharing one update datapath;
// a scan pointer updates one neuron per enabled cycle.
module lif_neuron_array #(
    parameter int N_NEURONS = 4,
    parameter int V_WIDTH   = 8,
    parameter int I_WIDTH   = 3,
    parameter int REF_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    lif_neuron_array_if.slave   bus
);
    localparam int IDX_W = $clog2(N_NEURONS);
    localparam int SH_W  = $clog2(V_WIDTH);
    localparam int S_W   = V_WIDTH + 1;
    localparam logic [IDX_W-1:0]     LAST  = IDX_W'(N_NEURONS - 1);
    localparam logic [V_WIDTH-1:0]   V_MAX = '1;
    localparam logic [N_NEURONS-1:0] ONE_HOT0 = N_NEURONS'(1);

    logic [V_WIDTH-1:0]   v_mem   [N_NEURONS];
    logic [REF_WIDTH-1:0] ref_mem [N_NEURONS];
    logic [IDX_W-1:0]     idx;

    logic [V_WIDTH-1:0]   threshold;
    logic [V_WIDTH-1:0]   decay;
    logic [REF_WIDTH-1:0] refractory;
    logic                 leak_mode;
    logic                 reset_mode;

    logic [N_NEURONS-1:0] spike_q;
    logic [V_WIDTH-1:0]   pot_q;
    logic [IDX_W-1:0]     pidx_q;
    logic                 done_q;

    logic [I_WIDTH-1:0]   cur_in [N_NEURONS];
    logic [V_WIDTH-1:0]   v_cur;
    logic [REF_WIDTH-1:0] ref_cur;
    logic [V_WIDTH-1:0]   leak;
    logic [S_W-1:0]       sum;
    logic [S_W-1:0]       diff;
    logic [V_WIDTH-1:0]   n_val;
    logic                 fire;
    logic [V_WIDTH-1:0]   v_next;
    logic [N_NEURONS-1:0] spike_vec;

    always_comb begin
        for (int k = 0; k < N_NEURONS; k++) begin
            cur_in[k] = bus.input_current[k*I_WIDTH +: I_WIDTH];
        end
    end

    // Saturating integrate/leak for the neuron under the scan pointer.
    always_comb begin
        v_cur   = v_mem[idx];
        ref_cur = ref_mem[idx];
        sum     = {1'b0, v_cur} + S_W'(cur_in[idx]);
        leak    = leak_mode ? (v_cur >> decay[SH_W-1:0]) : decay;
        diff    = sum - {1'b0, leak};
        if (sum < {1'b0, leak}) begin
            n_val = '0;
        end else if (diff[V_WIDTH]) begin
            n_val = V_MAX;
        end else begin
            n_val = diff[V_WIDTH-1:0];
        end
        fire      = (threshold != '0) && (n_val >= threshold);
        v_next    = fire ? (reset_mode ? n_val - threshold : '0) : n_val;
        spike_vec = fire ? (ONE_HOT0 << idx) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            threshold  <= {1'b1, {(V_WIDTH-1){1'b0}}};
            decay      <= V_WIDTH'(1);
            refractory <= REF_WIDTH'(2);
            leak_mode  <= 1'b0;
            reset_mode <= 1'b0;
        end else if (bus.cfg_we) begin
            case (bus.cfg_sel)
                2'd0:    threshold  <= bus.cfg_data;
                2'd1:    decay      <= bus.cfg_data;
                2'd2:    refractory <= bus.cfg_data[REF_WIDTH-1:0];
                default: {reset_mode, leak_mode} <= bus.cfg_data[1:0];
            endcase
        end
    end

    // Refractory neurons only count down; spike and step pulses self-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                v_mem[k]   <= '0;
                ref_mem[k] <= '0;
            end
            idx     <= '0;
            spike_q <= '0;
            pot_q   <= '0;
            pidx_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            spike_q <= '0;
            done_q  <= 1'b0;
            if (bus.enable) begin
                if (ref_cur != '0) begin
                    ref_mem[idx] <= ref_cur - REF_WIDTH'(1);
                    pot_q        <= v_cur;
                end else begin
                    v_mem[idx] <= v_next;
                    pot_q      <= v_next;
                    spike_q    <= spike_vec;
                    if (fire) begin
                        ref_mem[idx] <= refractory;
                    end
                end
                pidx_q <= idx;
                done_q <= (idx == LAST);
                idx    <= (idx == LAST) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    assign bus.spike_out     = spike_q;
    assign bus.potential_out = pot_q;
    assign bus.potential_idx = pidx_q;
    assign bus.step_done     = done_q;
endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array: scenario tasks compared against
// an integer-arithmetic reference model of the neuron array.
module tb_lif_neuron_array;
    localparam int N  = 4;
    localparam int VW = 8;
    localparam int IW = 3;
    localparam int RW = 8;
    localparam int VMAX = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    lif_neuron_array_if #(.N_NEURONS(N), .V_WIDTH(VW), .I_WIDTH(IW)) bus ();

    lif_neuron_array #(.N_NEURONS(N), .V_WIDTH(VW), .I_WIDTH(IW), .REF_WIDTH(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int m_v [N];
    int m_ref [N];
    int m_idx, m_thr, m_decay, m_refr, m_mode;
    logic [N-1:0]  exp_spike;
    logic [VW-1:0] exp_pot;
    logic [1:0]    exp_pidx;
    logic          exp_done;
    int total = 0;
    int passed = 0;

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_v[k]   = 0;
            m_ref[k] = 0;
        end
        m_idx = 0; m_thr = 128; m_decay = 1; m_refr = 2; m_mode = 0;
        exp_spike = '0; exp_pot = '0; exp_pidx = '0; exp_done = 1'b0;
    endfunction

    // Advances the reference model by one clock using the current inputs,
    // then lets the DUT take the same edge and settles 1 time unit past it.
    task automatic tick();
        int k, cur, leak, n;
        exp_spike = '0;
        exp_done  = 1'b0;
        if (bus.enable) begin
            k = m_idx;
            if (m_ref[k] != 0) begin
                m_ref[k] = m_ref[k] - 1;
            end else begin
                cur  = (int'(bus.input_current) >> (k * IW)) & ((1 << IW) - 1);
                leak = (m_mode % 2 == 1) ? (m_v[k] >> (m_decay % VW)) : m_decay;
                n = m_v[k] + cur - leak;
                if (n < 0) n = 0;
                if (n > VMAX) n = VMAX;
                if (m_thr != 0 && n >= m_thr) begin
                    exp_spike[k] = 1'b1;
                    m_v[k]   = (m_mode / 2 == 1) ? n - m_thr : 0;
                    m_ref[k] = m_refr;
                end else begin
                    m_v[k] = n;
                end
            end
            exp_pot  = VW'(m_v[k]);
            exp_pidx = 2'(k);
            exp_done = (k == N - 1);
            m_idx    = (k + 1) % N;
        end
        if (bus.cfg_we) begin
            case (bus.cfg_sel)
                2'd0: m_thr   = int'(bus.cfg_data);
                2'd1: m_decay = int'(bus.cfg_data);
                2'd2: m_refr  = int'(bus.cfg_data) % (1 << RW);
                default: m_mode = int'(bus.cfg_data) % 4;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [1:0] sel, input logic [VW-1:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = sel;
        bus.cfg_data = data;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (bus.spike_out !== '0) $display("[TB] FAIL reset_spike: got %h want 0", bus.spike_out);
        else passed++;
        total++;
        if (bus.potential_out !== '0) $display("[TB] FAIL reset_pot: got %0d want 0", bus.potential_out);
        else passed++;
        total++;
        if (bus.potential_idx !== '0) $display("[TB] FAIL reset_idx: got %0d want 0", bus.potential_idx);
        else passed++;
        total++;
        if (bus.step_done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", bus.step_done);
        else passed++;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_default_scan();
        int seq [5] = '{2, 4, 6, 8, 0};
        int upd;
        do_reset();
        bus.enable = 1'b0;
        write_cfg(2'd0, 8'd10);
        write_cfg(2'd1, 8'd1);
        write_cfg(2'd2, 8'd2);
        write_cfg(2'd3, 8'd0);
        bus.input_current = 12'd3;
        bus.enable = 1'b1;
        for (int c = 0; c < 56; c++) begin
            tick();
            total++;
            if ({bus.spike_out, bus.potential_out, bus.potential_idx, bus.step_done} !==
                {exp_spike, exp_pot, exp_pidx, exp_done})
                $display("[TB] FAIL default_model c=%0d: got %h/%0d/%0d/%b want %h/%0d/%0d/%b", c,
                         bus.spike_out, bus.potential_out, bus.potential_idx, bus.step_done,
                         exp_spike, exp_pot, exp_pidx, exp_done);
            else passed++;
            if (c % 4 == 0) begin
                upd = c / 4 + 1;
                total++;
                if (bus.spike_out[0] !== ((upd == 5) || (upd == 12)))
                    $display("[TB] FAIL default_spike0 upd=%0d: got %b want %b", upd,
                             bus.spike_out[0], ((upd == 5) || (upd == 12)));
                else passed++;
                if (upd <= 5) begin
                    total++;
                    if (bus.potential_out !== VW'(seq[upd-1]))
                        $display("[TB] FAIL default_v0 upd=%0d: got %0d want %0d", upd,
                                 bus.potential_out, seq[upd-1]);
                    else passed++;
                end
            end else begin
                total++;
                if (bus.potential_out !== '0)
                    $display("[TB] FAIL default_other c=%0d: got %0d want 0", c, bus.potential_out);
                else passed++;
            end
        end
    endtask

    task automatic test_saturation();
        logic [VW-1:0] last_v0;
        do_reset();
        bus.enable = 1'b0;
        write_cfg(2'd0, 8'd0);
        write_cfg(2'd1, 8'd0);
        bus.input_current = {3'($urandom), 3'($urandom), 3'($urandom), 3'd7};
        bus.enable = 1'b1;
        last_v0 = '0;
        for (int c = 0; c < 160; c++) begin
            tick();
            total++;
            if ({bus.spike_out, bus.potential_out, bus.potential_idx, bus.step_done} !==
                {exp_spike, exp_pot, exp_pidx, exp_done})
                $display("[TB] FAIL sat_model c=%0d: got %h/%0d/%0d/%b want %h/%0d/%0d/%b", c,
                         bus.spike_out, bus.potential_out, bus.potential_idx, bus.step_done,
                         exp_spike, exp_pot, exp_pidx, exp_done);
            else passed++;
            if (c % 4 == 0) last_v0 = bus.potential_out;
        end
        total++;
        if (last_v0 !== 8'd255) $display("[TB] FAIL sat_hold: got %0d want 255", last_v0);
        else passed++;
    endtask

    task automatic test_subtractive();
        int exp_v [4] = '{7, 4, 1, 8};
        int exp_s [4] = '{0, 1, 1, 0};
        do_reset();
        bus.enable = 1'b0;
        write_cfg(2'd0, 8'd10);
        write_cfg(2'd1, 8'd0);
        write_cfg(2'd2, 8'd0);
        write_cfg(2'd3, 8'd2);
        bus.input_current = 12'd7;
        bus.enable = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tick();
            total++;
            if ({bus.spike_out, bus.potential_out, bus.potential_idx, bus.step_done} !==
                {exp_spike, exp_pot, exp_pidx, exp_done})
                $display("[TB] FAIL sub_model c=%0d: got %h/%0d/%0d/%b want %h/%0d/%0d/%b", c,
                         bus.spike_out, bus.potential_out, bus.potential_idx, bus.step_done,
                         exp_spike, exp_pot, exp_pidx, exp_done);
            else passed++;
            if (c % 4 == 0) begin
                total++;
                if ({bus.spike_out[0], bus.potential_out} !== {1'(exp_s[c/4]), VW'(exp_v[c/4])})
                    $display("[TB] FAIL sub_residual scan=%0d: got %b/%0d want %0d/%0d", c / 4,
                             bus.spike_out[0], bus.potential_out, exp_s[c/4], exp_v[c/4]);
                else passed++;
            end
        end
    endtask

    task automatic test_shift_leak();
        int leak_seq [3] = '{75, 57, 43};
        do_reset();
        bus.enable = 1'b0;
        write_cfg(2'd0, 8'd0);
        write_cfg(2'd1, 8'd0);
        bus.enable = 1'b1;
        for (int c = 0; c < 60; c++) begin
            bus.input_current = (c < 56) ? 12'd7 : 12'd2;
            tick();
            total++;
            if ({bus.spike_out, bus.potential_out, bus.potential_idx, bus.step_done} !==
                {exp_spike, exp_pot, exp_pidx, exp_done})
                $display("[TB] FAIL leak_pre c=%0d: got %h/%0d want %h/%0d", c,
                         bus.spike_out, bus.potential_out, exp_spike, exp_pot);
            else passed++;
        end
        bus.enable = 1'b0;
        write_cfg(2'd3, 8'd1);
        write_cfg(2'd1, 8'd2);
        bus.input_current = '0;
        bus.enable = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c % 4 == 0) begin
                total++;
                if (bus.potential_out !== VW'(leak_seq[c/4]))
                    $display("[TB] FAIL leak_shift scan=%0d: got %0d want %0d", c / 4,
                             bus.potential_out, leak_seq[c/4]);
                else passed++;
            end
        end
    endtask

    task automatic test_enable_gating();
        do_reset();
        bus.input_current = 12'($urandom);
        bus.enable = 1'b1;
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            bus.enable = 1'b0;
            bus.input_current = 12'($urandom);
            tick();
            total++;
            if ({bus.spike_out, bus.potential_out, bus.potential_idx, bus.step_done} !==
                {4'b0, exp_pot, 2'd1, 1'b0})
                $display("[TB] FAIL gate_hold c=%0d: got %h/%0d/%0d/%b want 0/%0d/1/0", c,
                         bus.spike_out, bus.potential_out, bus.potential_idx, bus.step_done, exp_pot);
            else passed++;
        end
        bus.enable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if ({bus.spike_out, bus.potential_out, bus.potential_idx, bus.step_done} !==
                {exp_spike, exp_pot, exp_pidx, exp_done})
                $display("[TB] FAIL gate_model c=%0d: got %h/%0d/%0d/%b want %h/%0d/%0d/%b", c,
                         bus.spike_out, bus.potential_out, bus.potential_idx, bus.step_done,
                         exp_spike, exp_pot, exp_pidx, exp_done);
            else passed++;
            total++;
            if ({bus.potential_idx, bus.step_done} !== {2'(c + 2), (c == 1)})
                $display("[TB] FAIL gate_resume c=%0d: got idx %0d done %b want idx %0d done %b", c,
                         bus.potential_idx, bus.step_done, (c + 2) % 4, (c == 1));
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.enable = 1'b0;
        write_cfg(2'd2, 8'd200);
        write_cfg(2'd0, 8'd5);
        bus.input_current = 12'd7;
        bus.enable = 1'b1;
        tick();
        total++;
        if (bus.spike_out[0] !== 1'b1) $display("[TB] FAIL async_prefire: got %b want 1", bus.spike_out[0]);
        else passed++;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({bus.spike_out, bus.potential_out, bus.potential_idx, bus.step_done} !== '0)
            $display("[TB] FAIL async_clear: got %h/%0d/%0d/%b want all 0",
                     bus.spike_out, bus.potential_out, bus.potential_idx, bus.step_done);
        else passed++;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({bus.potential_idx, bus.potential_out} !== {2'd0, 8'd6})
            $display("[TB] FAIL async_restart: got idx %0d v %0d want idx 0 v 6",
                     bus.potential_idx, bus.potential_out);
        else passed++;
        m_v[0] = 6; m_idx = 1; exp_pot = 8'd6;
        tick(); tick(); tick();
        bus.cfg_we = 1'b1; bus.cfg_sel = 2'd0; bus.cfg_data = 8'd5;
        tick();
        bus.cfg_we = 1'b0;
        total++;
        if ({bus.spike_out[0], bus.potential_out} !== {1'b0, 8'd12})
            $display("[TB] FAIL same_edge_old: got %b/%0d want 0/12", bus.spike_out[0], bus.potential_out);
        else passed++;
        tick(); tick(); tick(); tick();
        total++;
        if ({bus.spike_out[0], bus.potential_out} !== {1'b1, 8'd0})
            $display("[TB] FAIL same_edge_new: got %b/%0d want 1/0", bus.spike_out[0], bus.potential_out);
        else passed++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            bus.enable        = ($urandom_range(0, 9) < 8);
            bus.input_current = 12'($urandom);
            bus.cfg_we        = ($urandom_range(0, 9) == 0);
            bus.cfg_sel       = 2'($urandom);
            bus.cfg_data      = 8'($urandom);
            tick();
            total++;
            if ({bus.spike_out, bus.potential_out, bus.potential_idx, bus.step_done} !==
                {exp_spike, exp_pot, exp_pidx, exp_done})
                $display("[TB] FAIL random_model c=%0d: got %h/%0d/%0d/%b want %h/%0d/%0d/%b", c,
                         bus.spike_out, bus.potential_out, bus.potential_idx, bus.step_done,
                         exp_spike, exp_pot, exp_pidx, exp_done);
            else passed++;
        end
        bus.cfg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.enable = 1'b0;
        bus.input_current = '0;
        bus.cfg_we = 1'b0;
        bus.cfg_sel = '0;
        bus.cfg_data = '0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_default_scan();
        test_saturation();
        test_subtractive();
        test_shift_leak();
        test_enable_gating();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
